phase_readout_arbiter: RTL and testbench

Round-robin readout scheduler that shares one serial output link between `NUM_CH` phase-detector FIFOs. It picks a non-empty FIFO and issues one read strobe. It then waits out the FIFO's fixed (non-first-word-fall-through) read latency, captures the word and tags it with its channel number. Finally it launches the serializer and holds off until the frame has gone out. It sits between the per-channel phase-detector/FIFO wrappers and the SPI serializer, in the FIFO read-clock domain.

---
 rtl/phase_readout_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_phase_readout_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_readout_arbiter.sv
// phase_readout_arbiter: round-robin readout scheduler that drains NUM_CH
// phase-detector FIFOs one word at a time onto a shared serializer link.
// Each frame: grant -> read strobe -> wait read latency -> capture/tag ->
// launch serializer -> wait for the frame to go out.
// Optional build macro: PHASE_ARB_TIMEOUT_EN adds a 16-bit watchdog on the
// serializer handshake (ARM/DRAIN) that sets a sticky ser_err on expiry.
module phase_readout_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        fifo_empty,
  output logic [NUM_CH-1:0]        fifo_rd_en,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic                     ser_go,
  output logic [CH_W+DATA_W-1:0]   ser_data,
  input  logic                     ser_busy,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic                     ser_err
);

  localparam int LAT_W = 2;  // holds RD_LAT-1 for RD_LAT up to 4

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_SEND, S_ARM, S_DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]          grant_q, grant_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [NUM_CH-1:0]        rd_en_q, rd_en_d;
  logic                     ser_go_q, ser_go_d;
  logic [CH_W+DATA_W-1:0]   ser_data_q, ser_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;

  logic                     pick_vld;
  logic [CH_W-1:0]          pick;
  logic [CH_W-1:0]          nxt_ptr;
  logic [DATA_W-1:0]        word;

`ifdef PHASE_ARB_TIMEOUT_EN
  logic [15:0]              wdog_q, wdog_d;
  logic                     ser_err_q, ser_err_d;
`endif

  // First non-empty channel at or after rr_ptr, wrapping modulo NUM_CH
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_CH;
      if (!pick_vld && !fifo_empty[idx]) begin
        pick_vld = 1'b1;
        pick     = CH_W'(idx);
      end
    end
  end

  assign nxt_ptr = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
  assign word    = fifo_data[int'(grant_q)*DATA_W +: DATA_W];

  // Next-state and registered-output logic for the readout sequence
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    lat_d       = lat_q;
    rd_en_d     = '0;
    ser_go_d    = 1'b0;
    out_valid_d = 1'b0;
    ser_data_d  = ser_data_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
`ifdef PHASE_ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
    ser_err_d   = ser_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Strobe and latency count are loaded on the way into READ so the
        // strobe is visible in the READ cycle and the count lines up with it.
        if (pick_vld) begin
          grant_d = pick;
          rd_en_d = NUM_CH'(1) << pick;
          lat_d   = LAT_W'(RD_LAT - 1);
          state_d = S_READ;
        end
      end
      S_READ, S_WAIT: begin
        // READ and WAIT share the countdown; with RD_LAT=1 the word is
        // taken straight from READ.
        if (lat_q == '0) begin
          out_data_d  = word;
          out_ch_d    = grant_q;
          ser_data_d  = {grant_q, word};
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end else begin
          lat_d   = lat_q - LAT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        ser_go_d = 1'b1;
        state_d  = S_ARM;
`ifdef PHASE_ARB_TIMEOUT_EN
        wdog_d   = '0;
`endif
      end
      S_ARM: begin
        // Busy seen during the go cycle itself is stale and ignored.
        if (!ser_go_q && ser_busy) begin
          state_d = S_DRAIN;
`ifdef PHASE_ARB_TIMEOUT_EN
          wdog_d  = '0;
        end else if (wdog_q == '1) begin
          ser_err_d = 1'b1;
          rr_ptr_d  = nxt_ptr;
          state_d   = S_IDLE;
        end else begin
          wdog_d    = wdog_q + 16'd1;
`endif
        end
      end
      S_DRAIN: begin
        if (!ser_busy) begin
          rr_ptr_d = nxt_ptr;
          state_d  = S_IDLE;
`ifdef PHASE_ARB_TIMEOUT_EN
        end else if (wdog_q == '1) begin
          ser_err_d = 1'b1;
          rr_ptr_d  = nxt_ptr;
          state_d   = S_IDLE;
        end else begin
          wdog_d    = wdog_q + 16'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      lat_q       <= '0;
      rd_en_q     <= '0;
      ser_go_q    <= 1'b0;
      ser_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      lat_q       <= lat_d;
      rd_en_q     <= rd_en_d;
      ser_go_q    <= ser_go_d;
      ser_data_q  <= ser_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef PHASE_ARB_TIMEOUT_EN
  // Watchdog count and sticky error, cleared only by reset
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      ser_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      ser_err_q <= ser_err_d;
    end
  end
  assign ser_err = ser_err_q;
`else
  assign ser_err = 1'b0;
`endif

  assign fifo_rd_en = rd_en_q;
  assign ser_go     = ser_go_q;
  assign ser_data   = ser_data_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_phase_readout_arbiter.sv
// Directed bench for phase_readout_arbiter (NUM_CH=4, DATA_W=8, RD_LAT=2).
module tb_phase_readout_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int CH_W   = 2;

  logic                     sys_clk = 1'b0;
  logic                     rst_n   = 1'b0;
  logic [NUM_CH-1:0]        fifo_empty = '1;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic                     ser_go;
  logic [CH_W+DATA_W-1:0]   ser_data;
  logic                     ser_busy = 1'b0;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic [DATA_W-1:0]        out_data;
  logic                     ser_err;

  int  checks = 0;
  int  errors = 0;
  bit  ser_auto = 1'b1;
  int  busy_len = 3;

  // Per-channel head-of-FIFO words: ch0=3C ch1=5E ch2=A5 ch3=C7
  assign fifo_data = {8'hC7, 8'hA5, 8'h5E, 8'h3C};

  always #5 sys_clk = ~sys_clk;

  phase_readout_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .ser_go    (ser_go),
    .ser_data  (ser_data),
    .ser_busy  (ser_busy),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .ser_err   (ser_err)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Wait (bounded) for a read strobe; returns the strobed channel or -1.
  task automatic wait_rd(input int limit, output int ch);
    ch = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (fifo_rd_en != '0) begin
        for (int b = 0; b < NUM_CH; b++) if (fifo_rd_en[b]) ch = b;
        break;
      end
    end
  endtask

  // Serializer model: goes busy right after seeing ser_go, for busy_len cycles
  initial begin
    forever begin
      tick();
      if (ser_auto && ser_go === 1'b1) begin
        ser_busy = 1'b1;
        repeat (busy_len) tick();
        ser_busy = 1'b0;
      end
    end
  end

  initial begin
    int ch;
    bit seen;

    // Reset state
    repeat (3) tick();
    chk("rst_rd_en",     fifo_rd_en, 0);
    chk("rst_ser_go",    ser_go,     0);
    chk("rst_ser_data",  ser_data,   0);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_out_ch",    out_ch,     0);
    chk("rst_out_data",  out_data,   0);
    chk("rst_ser_err",   ser_err,    0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (fifo_rd_en != '0) seen = 1'b1;
    end
    chk("idle_no_rd_en", seen, 0);

    // Single channel read: only ch2 holds a word
    fifo_empty = 4'b1011;
    tick();
    chk("single_rd_en", fifo_rd_en, 4'b0100);
    fifo_empty = 4'b1111;
    tick();
    chk("single_rd_en_once", fifo_rd_en, 0);
    chk("single_no_valid_early", out_valid, 0);
    tick();
    chk("single_out_valid", out_valid, 1);
    chk("single_out_ch",    out_ch,    2);
    chk("single_out_data",  out_data,  8'hA5);
    tick();
    chk("single_ser_go",    ser_go,    1);
    chk("single_ser_data",  ser_data,  10'h2A5);
    chk("single_valid_pulse", out_valid, 0);
    tick();
    chk("single_ser_go_pulse", ser_go, 0);
    chk("single_ser_data_hold", ser_data, 10'h2A5);
    repeat (20) tick();

    // Wrap and skip: pointer is 3, only ch1 pending -> ch1; pointer then 2
    fifo_empty = 4'b1101;
    wait_rd(50, ch);
    fifo_empty = 4'b1111;
    chk("wrap_grant_ch1", ch, 1);
    repeat (20) tick();
    fifo_empty = 4'b1001;
    wait_rd(50, ch);
    fifo_empty = 4'b1111;
    chk("ptr2_grant_ch2", ch, 2);
    repeat (20) tick();

    // Mid-frame reset: ch3 granted, reset lands in WAIT
    fifo_empty = 4'b0111;
    wait_rd(50, ch);
    fifo_empty = 4'b1111;
    chk("mid_grant_ch3", ch, 3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en",    fifo_rd_en, 0);
    chk("mid_rst_out_data", out_data,   0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (ser_go || out_valid) seen = 1'b1;
    end
    chk("mid_no_ser_go", seen, 0);
    chk("mid_ser_data_clear", ser_data, 0);

    // Fairness: all channels always pending, 10-cycle frames
    busy_len   = 10;
    fifo_empty = 4'b0000;
    for (int f = 0; f < 6; f++) begin
      wait_rd(100, ch);
      if (f == 5) fifo_empty = 4'b1111;
      chk($sformatf("rr_grant_%0d", f), ch, f % NUM_CH);
      repeat (2) tick();
      chk($sformatf("rr_valid_%0d", f), out_valid, 1);
      chk($sformatf("rr_out_ch_%0d", f), out_ch, f % NUM_CH);
    end
    repeat (30) tick();

`ifdef PHASE_ARB_TIMEOUT_EN
    // Timeout: serializer never responds on ch2's frame; ch3 is next
    ser_auto   = 1'b0;
    fifo_empty = 4'b0011;
    wait_rd(50, ch);
    chk("to_grant_ch2", ch, 2);
    chk("to_err_before", ser_err, 0);
    seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (ser_err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("to_ser_err", seen, 1);
    ser_auto = 1'b1;
    wait_rd(50, ch);
    fifo_empty = 4'b1111;
    chk("to_next_ch3", ch, 3);
    repeat (30) tick();
    chk("to_err_sticky", ser_err, 1);
`else
    chk("no_timeout_ser_err", ser_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
